// File: rtl/spi_write_controller.sv
// spi_write_controller: SPI mode-0 controller that sends 16-bit register frames
// {rw, addr[6:0], wdata[7:0]} MSB-first, framed by an active-low chip select.
// Optional feature macro: SPI_READ_EN. When it is defined, spi_cipo is sampled
// during bits 7..0 of read frames and the byte is presented on rdata.
// Every phase (SETUP, each SCLK high/low half, GAP) lasts CLK_DIV clk cycles.
module spi_write_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_ncs,
  input  logic       spi_cipo
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bit_reg, bit_next;
  logic [15:0]      shift_reg, shift_next;

  logic ready_next, busy_next, done_next, sclk_next, copi_next, ncs_next;
  logic phase_end;
  logic accept;

  assign phase_end = (cnt_reg == CNT_W'(CLK_DIV - 1));
  // req_ready is registered from the IDLE state, so it marks acceptance exactly
  assign accept    = req_valid && req_ready;

  // State, counters, frame shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_copi  <= 1'b0;
      spi_ncs   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      req_ready <= ready_next;
      busy      <= busy_next;
      done      <= done_next;
      spi_sclk  <= sclk_next;
      spi_copi  <= copi_next;
      spi_ncs   <= ncs_next;
    end
  end

  // Phase sequencing: each phase runs for CLK_DIV cycles, then advances
  always_comb begin
    state_next = state_reg;
    cnt_next   = phase_end ? '0 : cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (accept) begin
          state_next = SETUP;
          bit_next   = 4'd15;
          shift_next = {req_rw, req_addr, req_wdata};
        end
      end
      SETUP: begin
        if (phase_end) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        // Falling SCLK edge: move the next bit onto COPI
        if (phase_end) begin
          state_next = SHIFT_LO;
          shift_next = {shift_reg[14:0], 1'b0};
        end
      end
      SHIFT_LO: begin
        // The low half of bit 0 doubles as the nCS hold time
        if (phase_end) begin
          if (bit_reg == 4'd0) begin
            state_next = GAP;
          end else begin
            state_next = SHIFT_HI;
            bit_next   = bit_reg - 4'd1;
          end
        end
      end
      GAP: begin
        if (phase_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the upcoming state
  always_comb begin
    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
    ncs_next   = !((state_next == SETUP) || (state_next == SHIFT_HI) ||
                   (state_next == SHIFT_LO));
    sclk_next  = (state_next == SHIFT_HI);
    copi_next  = ncs_next ? 1'b0 : shift_next[15];
    done_next  = (state_reg == SHIFT_LO) && phase_end && (bit_reg == 4'd0);
  end

`ifdef SPI_READ_EN
  logic       rw_reg;
  logic [7:0] rx_reg;
  logic       sclk_rise;

  assign sclk_rise = (state_next == SHIFT_HI) && (state_reg != SHIFT_HI);

  // Capture CIPO on SCLK rising edges of the data byte; publish it with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_reg <= 1'b0;
      rx_reg <= '0;
      rdata  <= '0;
    end else begin
      if (accept) rw_reg <= req_rw;
      if (sclk_rise && (bit_next < 4'd8)) rx_reg <= {rx_reg[6:0], spi_cipo};
      if (done_next && !rw_reg) rdata <= rx_reg;
    end
  end
`else
  assign rdata = 8'h00;
  wire _unused = &{1'b0, spi_cipo};
`endif

endmodule

// File: tb/tb_spi_write_controller.sv
// tb_spi_write_controller: randomized frames against a bus-level peripheral
// model that records COPI on every SCLK rise while nCS is low, and checks
// framing lengths, done pulses, spacing and (optionally) read data.
module tb_spi_write_controller;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       busy, done;
  logic [7:0] rdata;
  logic       spi_sclk, spi_copi, spi_ncs;
  logic       spi_cipo = 1'b0;

  int errors = 0;
  int checks = 0;

  spi_write_controller #(.CLK_DIV(H)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .spi_sclk(spi_sclk),
    .spi_copi(spi_copi), .spi_ncs(spi_ncs), .spi_cipo(spi_cipo)
  );

  always #5 clk = ~clk;

  // Peripheral / bus monitor state
  logic [15:0] cap;
  int          rises, low_run, hi_run, cyc, overlap;
  logic        prev_ncs, prev_sclk, prev_busy, seen_frame;
  logic [7:0]  cur_rbyte;
  logic [7:0]  exp_rdata = 8'h00;
  logic [15:0] frames_q[$];
  int          rises_q[$], lows_q[$], gaps_q[$], done_q[$], brise_q[$];
  logic [7:0]  rdone_q[$];

  task automatic clear_mon();
    cap = '0; rises = 0; low_run = 0; hi_run = 0; cyc = 0; overlap = 0;
    prev_ncs = spi_ncs; prev_sclk = spi_sclk; prev_busy = busy; seen_frame = 1'b0;
    frames_q.delete(); rises_q.delete(); lows_q.delete(); gaps_q.delete();
    done_q.delete(); brise_q.delete(); rdone_q.delete();
  endtask

  // Called once per cycle right after a falling clk edge
  task automatic sample_cycle();
    int idx;
    cyc++;
    if (!spi_ncs) begin
      low_run++;
      if (spi_sclk && !prev_sclk) begin
        cap = {cap[14:0], spi_copi};
        rises++;
      end
    end
    if (spi_ncs) hi_run++;
    if (!spi_ncs && prev_ncs) begin
      if (seen_frame) gaps_q.push_back(hi_run);
      hi_run = 0;
    end
    if (spi_ncs && !prev_ncs) begin
      frames_q.push_back(cap); rises_q.push_back(rises); lows_q.push_back(low_run);
      cap = '0; rises = 0; low_run = 0; hi_run = 1; seen_frame = 1'b1;
    end
    if (done) begin
      done_q.push_back(cyc);
      rdone_q.push_back(rdata);
    end
    if (done && req_ready) overlap++;
    if (busy && !prev_busy) brise_q.push_back(cyc);
    prev_ncs = spi_ncs; prev_sclk = spi_sclk; prev_busy = busy;
    idx = 15 - rises;
    spi_cipo = (!spi_ncs && rises >= 8 && rises < 16) ? cur_rbyte[idx[2:0]] : 1'b0;
  endtask

  // Runs one frame; poke_rise >= 0 pulses req_valid (wdata=FF) after that many rises
  task automatic do_frame(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rbyte, input int poke_rise, input string name);
    logic [15:0] exp_frame;
    logic poked, finished;
    exp_frame = {rw, addr, wdata};
    clear_mon();
    cur_rbyte = rbyte;
    poked = 1'b0; finished = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
    sample_cycle();
    @(negedge clk); req_valid = 1'b0;
    req_rw = 1'($urandom); req_addr = 7'($urandom); req_wdata = 8'($urandom);
    sample_cycle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      sample_cycle();
      if (poked) req_valid = 1'b0;
      if (poke_rise >= 0 && !poked && rises == poke_rise) begin
        req_valid = 1'b1; req_wdata = 8'hFF; poked = 1'b1;
      end
      if (req_ready) begin finished = 1'b1; break; end
    end
    req_valid = 1'b0;
`ifdef SPI_READ_EN
    if (!rw) exp_rdata = rbyte;
`endif
    checks++;
    if (!finished || frames_q.size() != 1 || done_q.size() != 1 || brise_q.size() != 1) begin
      errors++;
      $display("FAIL %s_frames: got frames=%0d dones=%0d busy_rises=%0d finished=%0d required 1/1/1/1",
               name, frames_q.size(), done_q.size(), brise_q.size(), finished);
    end else begin
      checks++;
      if (frames_q[0] !== exp_frame) begin
        errors++; $display("FAIL %s_capture: got %h required %h", name, frames_q[0], exp_frame);
      end
      checks++;
      if (rises_q[0] != 16) begin
        errors++; $display("FAIL %s_rises: got %0d required 16", name, rises_q[0]);
      end
      checks++;
      if (lows_q[0] != 33 * H) begin
        errors++; $display("FAIL %s_ncs_low: got %0d required %0d", name, lows_q[0], 33 * H);
      end
      checks++;
      if (done_q[0] - brise_q[0] != 33 * H) begin
        errors++; $display("FAIL %s_done_time: got %0d required %0d", name, done_q[0] - brise_q[0], 33 * H);
      end
      checks++;
      if (cyc - brise_q[0] != 34 * H) begin
        errors++; $display("FAIL %s_busy_len: got %0d required %0d", name, cyc - brise_q[0], 34 * H);
      end
      checks++;
      if (rdone_q[0] !== exp_rdata) begin
        errors++; $display("FAIL %s_rdata_done: got %h required %h", name, rdone_q[0], exp_rdata);
      end
    end
    checks++;
    if (rdata !== exp_rdata || overlap != 0) begin
      errors++; $display("FAIL %s_rdata_hold: got %h overlap=%0d required %h overlap=0", name, rdata, overlap, exp_rdata);
    end
    $display("frame %s: rw=%0d addr=%h wdata=%h captured=%h rdata=%h", name, rw, addr, wdata,
             (frames_q.size() > 0) ? frames_q[0] : 16'h0000, rdata);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, busy, done, rdata, spi_sclk, spi_copi, spi_ncs} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got ready=%b busy=%b done=%b rdata=%h sclk=%b copi=%b ncs=%b required 1 0 0 00 0 0 1",
               req_ready, busy, done, rdata, spi_sclk, spi_copi, spi_ncs);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || spi_ncs !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%b ncs=%b busy=%b required 1 1 0", req_ready, spi_ncs, busy);
    end
    $display("reset: ready=%b ncs=%b sclk=%b", req_ready, spi_ncs, spi_sclk);
  endtask

  task automatic test_write();
    do_frame(1'b1, 7'h00, 8'hA5, 8'h00, -1, "write");
  endtask

  task automatic test_read_type();
    do_frame(1'b0, 7'h7F, 8'h00, 8'h5A, -1, "read_type");
  endtask

  task automatic test_busy_request();
    do_frame(1'b1, 7'h11, 8'h22, 8'h00, 12, "busy_req");
    clear_mon();
    for (int n = 0; n < 60; n++) begin @(negedge clk); sample_cycle(); end
    checks++;
    if (brise_q.size() != 0 || spi_ncs !== 1'b1) begin
      errors++; $display("FAIL busy_req_extra: got busy_rises=%0d ncs=%b required 0 1", brise_q.size(), spi_ncs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      do_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom_range(255)), -1, $sformatf("random%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fa, fb;
    logic finished;
    fa = {1'b1, 7'($urandom), 8'($urandom)};
    fb = {1'b1, 7'($urandom), 8'($urandom)};
    finished = 1'b0;
    clear_mon();
    cur_rbyte = 8'h00;
    @(negedge clk); req_valid = 1'b1; {req_rw, req_addr, req_wdata} = fa;
    sample_cycle();
    @(negedge clk); {req_rw, req_addr, req_wdata} = fb;
    sample_cycle();
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      sample_cycle();
      if (brise_q.size() >= 2) begin
        req_valid = 1'b0; req_wdata = 8'($urandom);
      end
      if (done_q.size() == 2 && req_ready) begin finished = 1'b1; break; end
    end
    req_valid = 1'b0;
    checks++;
    if (!finished || frames_q.size() != 2 || brise_q.size() != 2 || gaps_q.size() != 1) begin
      errors++;
      $display("FAIL b2b_frames: got frames=%0d busy_rises=%0d gaps=%0d finished=%0d required 2/2/1/1",
               frames_q.size(), brise_q.size(), gaps_q.size(), finished);
    end else begin
      checks++;
      if (frames_q[0] !== fa || frames_q[1] !== fb) begin
        errors++; $display("FAIL b2b_capture: got %h %h required %h %h", frames_q[0], frames_q[1], fa, fb);
      end
      checks++;
      if (gaps_q[0] != H + 1) begin
        errors++; $display("FAIL b2b_ncs_gap: got %0d required %0d", gaps_q[0], H + 1);
      end
      checks++;
      if (brise_q[1] - done_q[0] != H + 1) begin
        errors++; $display("FAIL b2b_done_to_accept: got %0d required %0d", brise_q[1] - done_q[0], H + 1);
      end
      checks++;
      if (brise_q[1] - brise_q[0] != 34 * H + 1) begin
        errors++; $display("FAIL b2b_spacing: got %0d required %0d", brise_q[1] - brise_q[0], 34 * H + 1);
      end
    end
    $display("back_to_back: frames=%0d gap=%0d", frames_q.size(), (gaps_q.size() > 0) ? gaps_q[0] : -1);
  endtask

  task automatic test_mid_reset();
    logic hit;
    hit = 1'b0;
    clear_mon();
    @(negedge clk); req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h55; req_wdata = 8'hFF;
    sample_cycle();
    @(negedge clk); req_valid = 1'b0;
    sample_cycle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      sample_cycle();
      if (rises == 7) begin hit = 1'b1; break; end
    end
    rst = 1'b1;
    #1;
    exp_rdata = 8'h00;
    checks++;
    if (!hit || {spi_ncs, spi_sclk, spi_copi, req_ready, busy, done, rdata} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset_outputs: got hit=%b ncs=%b sclk=%b copi=%b ready=%b busy=%b done=%b rdata=%h required 1 1 0 0 1 0 0 00",
               hit, spi_ncs, spi_sclk, spi_copi, req_ready, busy, done, rdata);
    end
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 150; n++) begin @(negedge clk); sample_cycle(); end
    checks++;
    if (done_q.size() != 0 || brise_q.size() != 1 || spi_ncs !== 1'b1) begin
      errors++; $display("FAIL mid_reset_abort: got dones=%0d busy_rises=%0d ncs=%b required 0 1 1",
                         done_q.size(), brise_q.size(), spi_ncs);
    end
    $display("mid_reset: rises_at_reset=%0d dones=%0d", 7, done_q.size());
  endtask

`ifdef SPI_READ_EN
  task automatic test_read_en();
    do_frame(1'b0, 7'h02, 8'h00, 8'h3C, -1, "read_en");
    do_frame(1'b1, 7'h03, 8'h81, 8'hC3, -1, "read_en_hold");
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_type();
    test_back_to_back();
    test_busy_request();
    test_random();
`ifdef SPI_READ_EN
    test_read_en();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
